// File: rtl/proc_sequencer.sv
// Multicycle fetch/decode/execute/memory sequencer for the 8-bit accumulator processor.
// Optional macro PROC_SEQ_PERFCNT_EN adds retired-instruction and stall-cycle counters.
module proc_sequencer #(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       mem_rdy,
    input  logic [7:0] instr,
    input  logic       acc_zero,
    output logic       ir_we,
    output logic       pc_inc,
    output logic       brnch,
    output logic       mem_sel,
    output logic       mem_we,
    output logic       reg_we,
    output logic       lw_sel,
    output logic       acc_we,
    output logic       acc_sel,
    output logic [1:0] alu_ctl,
    output logic       busy,
    output logic       halted,
    output logic       fault
`ifdef PROC_SEQ_PERFCNT_EN
    ,
    output logic [15:0] retired,
    output logic [15:0] stall_cycles
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [2:0] OP_LI   = 3'b011;
    localparam logic [2:0] OP_LACC = 3'b100;
    localparam logic [2:0] OP_LW   = 3'b101;
    localparam logic [2:0] OP_SW   = 3'b110;
    localparam logic [2:0] OP_BRZ  = 3'b111;
    localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

    state_t     state_q;
    logic [2:0] opcode_q;
    logic [4:0] imm_q;
    logic [7:0] wait_q;
    logic       fault_q;

    logic wait_phase;
    logic timeout;

    assign wait_phase = (state_q == S_FETCH) || (state_q == S_MEM);
    // A ready arriving on the limit cycle still wins over the timeout.
    assign timeout    = wait_phase && !mem_rdy && (wait_q == WAIT_LIM);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            opcode_q <= '0;
            imm_q    <= '0;
            wait_q   <= '0;
            fault_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    wait_q <= '0;
                    if (start) state_q <= S_FETCH;
                end
                S_FETCH: begin
                    if (mem_rdy) begin
                        opcode_q <= instr[7:5];
                        imm_q    <= instr[4:0];
                        state_q  <= S_DECODE;
                    end else if (timeout) begin
                        fault_q <= 1'b1;
                        state_q <= S_HALT;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                S_DECODE: begin
                    wait_q <= '0;
                    if ({opcode_q, imm_q} == 8'hFF) state_q <= S_HALT;
                    else if (opcode_q == OP_LW || opcode_q == OP_SW) state_q <= S_MEM;
                    else state_q <= S_EXEC;
                end
                S_EXEC: begin
                    wait_q  <= '0;
                    state_q <= S_FETCH;
                end
                S_MEM: begin
                    if (mem_rdy) begin
                        wait_q  <= '0;
                        state_q <= S_FETCH;
                    end else if (timeout) begin
                        fault_q <= 1'b1;
                        state_q <= S_HALT;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                S_HALT: begin
                    wait_q <= '0;
                    if (start && !fault_q) state_q <= S_FETCH;
                end
                default: begin
                    wait_q  <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        ir_we   = 1'b0;
        pc_inc  = 1'b0;
        brnch   = 1'b0;
        mem_sel = 1'b0;
        mem_we  = 1'b0;
        reg_we  = 1'b0;
        lw_sel  = 1'b0;
        acc_we  = 1'b0;
        acc_sel = 1'b0;
        alu_ctl = 2'b00;
        case (state_q)
            S_FETCH: ir_we = mem_rdy;
            S_EXEC: begin
                if (opcode_q[2] == 1'b0 && opcode_q[1:0] != 2'b11) begin
                    alu_ctl = opcode_q[1:0];
                    reg_we  = 1'b1;
                end else if (opcode_q == OP_LI) begin
                    acc_we  = 1'b1;
                    acc_sel = 1'b1;
                end else if (opcode_q == OP_LACC) begin
                    acc_we  = 1'b1;
                end
                brnch  = (opcode_q == OP_BRZ) && acc_zero;
                pc_inc = !brnch;
            end
            S_MEM: begin
                mem_sel = 1'b1;
                mem_we  = (opcode_q == OP_SW) && !timeout;
                if (mem_rdy) begin
                    reg_we = (opcode_q == OP_LW);
                    lw_sel = (opcode_q == OP_LW);
                    pc_inc = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign busy   = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted = (state_q == S_HALT);
    assign fault  = fault_q;

`ifdef PROC_SEQ_PERFCNT_EN
    logic [15:0] retired_q;
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            if (state_q == S_EXEC || (state_q == S_MEM && mem_rdy))
                retired_q <= retired_q + 16'd1;
            if (wait_phase && !mem_rdy && stall_q != 16'hFFFF)
                stall_q <= stall_q + 16'd1;
        end
    end

    assign retired      = retired_q;
    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_proc_sequencer.sv
// Self-checking bench for proc_sequencer: directed plus randomized instruction streams
// checked cycle by cycle against per-instruction expected output traces.
module tb_proc_sequencer;

    localparam int WAIT_MAX = 15;

    localparam int B_IR = 13, B_PC = 12, B_BR = 11, B_MS = 10, B_MW = 9, B_RW = 8;
    localparam int B_LS = 7, B_AW = 6, B_AS = 5, B_ALU = 3, B_BUSY = 2, B_HALT = 1, B_FLT = 0;

    logic       clk = 1'b0;
    logic       rst_n, start, mem_rdy, acc_zero;
    logic [7:0] instr;
    logic       ir_we, pc_inc, brnch, mem_sel, mem_we, reg_we, lw_sel, acc_we, acc_sel;
    logic [1:0] alu_ctl;
    logic       busy, halted, fault;
`ifdef PROC_SEQ_PERFCNT_EN
    logic [15:0] retired, stall_cycles;
`endif

    int total = 0;
    int bad   = 0;
    int exp_retired = 0;
    int exp_stall   = 0;

    always #5 clk = ~clk;

    proc_sequencer #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mem_rdy(mem_rdy), .instr(instr),
        .acc_zero(acc_zero), .ir_we(ir_we), .pc_inc(pc_inc), .brnch(brnch),
        .mem_sel(mem_sel), .mem_we(mem_we), .reg_we(reg_we), .lw_sel(lw_sel),
        .acc_we(acc_we), .acc_sel(acc_sel), .alu_ctl(alu_ctl), .busy(busy),
        .halted(halted), .fault(fault)
`ifdef PROC_SEQ_PERFCNT_EN
        , .retired(retired), .stall_cycles(stall_cycles)
`endif
    );

    function automatic logic [13:0] observed();
        return {ir_we, pc_inc, brnch, mem_sel, mem_we, reg_we, lw_sel,
                acc_we, acc_sel, alu_ctl, busy, halted, fault};
    endfunction

    task automatic check(input string tag, input logic [13:0] expv);
        logic [13:0] obs;
        obs = observed();
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, then advance past the edge.
    task automatic cyc(input string tag, input logic r, input logic [7:0] in,
                       input logic az, input logic st, input logic [13:0] e);
        mem_rdy  = r;
        instr    = in;
        acc_zero = az;
        start    = st;
        #1;
        check(tag, e);
        @(posedge clk);
        #1;
    endtask

    // Expected trace of one instruction, starting with the DUT in FETCH.
    task automatic do_instr(input logic [7:0] ins, input int fw, input int mw, input logic az);
        logic [2:0]  op;
        logic [13:0] base;
        logic [13:0] e;
        op   = ins[7:5];
        base = '0;
        base[B_BUSY] = 1'b1;
        for (int w = 0; w < fw; w++)
            cyc("fetch_wait", 1'b0, 8'($urandom), 1'($urandom), 1'($urandom), base);
        exp_stall += fw;
        e = base;
        e[B_IR] = 1'b1;
        cyc("fetch", 1'b1, ins, 1'($urandom), 1'($urandom), e);
        cyc("decode", 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), base);
        if (ins == 8'hFF) return;
        exp_retired++;
        if (op == 3'd5 || op == 3'd6) begin
            e = base;
            e[B_MS] = 1'b1;
            e[B_MW] = (op == 3'd6);
            for (int w = 0; w < mw; w++)
                cyc("mem_wait", 1'b0, 8'($urandom), 1'($urandom), 1'($urandom), e);
            exp_stall += mw;
            e[B_RW] = (op == 3'd5);
            e[B_LS] = (op == 3'd5);
            e[B_PC] = 1'b1;
            cyc("mem_done", 1'b1, 8'($urandom), 1'($urandom), 1'($urandom), e);
        end else begin
            e = base;
            if (op <= 3'd2) begin
                e[B_RW] = 1'b1;
                e[B_ALU +: 2] = op[1:0];
            end else if (op == 3'd3) begin
                e[B_AW] = 1'b1;
                e[B_AS] = 1'b1;
            end else if (op == 3'd4) begin
                e[B_AW] = 1'b1;
            end
            if (op == 3'd7 && az) e[B_BR] = 1'b1;
            else e[B_PC] = 1'b1;
            cyc("exec", 1'($urandom), 8'($urandom), az, 1'($urandom), e);
        end
    endtask

    initial begin
        logic [13:0] e;
        logic [13:0] busy_v;
        logic [7:0]  ins;
        int fw, mw;

        busy_v = '0;
        busy_v[B_BUSY] = 1'b1;
        rst_n = 1'b0; start = 1'b0; mem_rdy = 1'b0; acc_zero = 1'b0; instr = '0;
        @(posedge clk);
        #1;
        cyc("reset", 1'b1, 8'h00, 1'b0, 1'b1, '0);
        rst_n = 1'b1;
        cyc("idle_hold", 1'b1, 8'h61, 1'b1, 1'b0, '0);
        cyc("idle_start", 1'b1, 8'h61, 1'b1, 1'b1, '0);

        // Directed instructions
        do_instr(8'h61, 0, 0, 1'b0);
        do_instr(8'hA3, 0, 2, 1'b0);
        do_instr(8'hE2, 0, 0, 1'b1);
        do_instr(8'hE2, 0, 0, 1'b0);
        do_instr(8'h00, 1, 0, 1'b0);
        do_instr(8'h21, 0, 0, 1'b0);
        do_instr(8'h42, 0, 0, 1'b0);
        do_instr(8'h9F, 0, 0, 1'b0);
        do_instr(8'hC4, WAIT_MAX, WAIT_MAX, 1'b0);

        // Randomized instruction stream
        for (int n = 0; n < 40; n++) begin
            do ins = 8'($urandom); while (ins == 8'hFF);
            fw = ($urandom_range(0, 7) == 0) ? WAIT_MAX : int'($urandom_range(0, 3));
            mw = ($urandom_range(0, 7) == 0) ? WAIT_MAX : int'($urandom_range(0, 3));
            do_instr(ins, fw, mw, 1'($urandom));
        end

`ifdef PROC_SEQ_PERFCNT_EN
        total++;
        assert (retired === 16'(exp_retired)) else begin
            bad++;
            $error("FAIL retired: observed=%0d expected=%0d", retired, exp_retired);
        end
        total++;
        assert (stall_cycles === 16'(exp_stall)) else begin
            bad++;
            $error("FAIL stall_cycles: observed=%0d expected=%0d", stall_cycles, exp_stall);
        end
`endif

        // HALT instruction and resume without PC advance
        do_instr(8'hFF, 1, 0, 1'b0);
        e = '0;
        e[B_HALT] = 1'b1;
        cyc("halt_hold", 1'b1, 8'h00, 1'b1, 1'b0, e);
        cyc("halt_start", 1'b1, 8'h00, 1'b1, 1'b1, e);
        do_instr(8'h61, 0, 0, 1'b0);

        // SW timeout in MEM
        cyc("sw_fetch", 1'b1, 8'hC1, 1'b0, 1'b0, {1'b1, busy_v[12:0]});
        cyc("sw_decode", 1'b0, 8'h00, 1'b0, 1'b0, busy_v);
        e = busy_v;
        e[B_MS] = 1'b1;
        e[B_MW] = 1'b1;
        for (int w = 0; w < WAIT_MAX; w++)
            cyc("sw_wait", 1'b0, 8'h00, 1'b0, 1'b0, e);
        e[B_MW] = 1'b0;
        cyc("sw_timeout", 1'b0, 8'h00, 1'b0, 1'b0, e);
        e = '0;
        e[B_HALT] = 1'b1;
        e[B_FLT]  = 1'b1;
        for (int k = 0; k < 3; k++)
            cyc("fault_sticky", 1'b1, 8'h61, 1'b0, 1'b1, e);
        rst_n = 1'b0;
        cyc("fault_pre_reset", 1'b1, 8'h61, 1'b0, 1'b0, e);
        cyc("fault_cleared", 1'b1, 8'h61, 1'b0, 1'b1, '0);
        rst_n = 1'b1;

        // Fetch timeout after WAIT_MAX+1 cycles without ready
        cyc("idle_start2", 1'b0, 8'h00, 1'b0, 1'b1, '0);
        for (int w = 0; w <= WAIT_MAX; w++)
            cyc("fetch_timeout_wait", 1'b0, 8'h61, 1'b0, 1'b0, busy_v);
        e = '0;
        e[B_HALT] = 1'b1;
        e[B_FLT]  = 1'b1;
        cyc("fetch_fault", 1'b1, 8'h61, 1'b0, 1'b1, e);

        // Reset during a pending SW drops the write
        rst_n = 1'b0;
        cyc("reset2", 1'b0, 8'h00, 1'b0, 1'b0, e);
        rst_n = 1'b1;
        cyc("idle_start3", 1'b0, 8'h00, 1'b0, 1'b1, '0);
        cyc("sw2_fetch", 1'b1, 8'hC7, 1'b0, 1'b0, {1'b1, busy_v[12:0]});
        cyc("sw2_decode", 1'b0, 8'h00, 1'b0, 1'b0, busy_v);
        e = busy_v;
        e[B_MS] = 1'b1;
        e[B_MW] = 1'b1;
        cyc("sw2_wait", 1'b0, 8'h00, 1'b0, 1'b0, e);
        rst_n = 1'b0;
        cyc("sw2_wait_rst", 1'b0, 8'h00, 1'b0, 1'b0, e);
        cyc("sw2_aborted", 1'b0, 8'h00, 1'b0, 1'b0, '0);
        rst_n = 1'b1;
        cyc("idle_after_abort", 1'b1, 8'h00, 1'b0, 1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
